// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus transaction sequencer.
// Phase encoding is exported on phase_o, so the enum values are fixed.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_CSS  = 3'd1,
        PH_CA   = 3'd2,
        PH_LAT  = 3'd3,
        PH_DATA = 3'd4,
        PH_CSH  = 3'd5
    } hyper_phase_e;

    localparam int CA_CYCLES = 3;

endpackage

// File: rtl/hyperbus_phase_cnt.sv
// Loadable down-counter with enable and zero flag; loaded with N-1 so that
// zero marks the final cycle of an N-cycle phase.
module hyperbus_phase_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hyperbus_ck_sequencer.sv
// HyperBus CK-enable / CS# phase sequencer for a single transaction.
// Optional feature macro: HYPERBUS_DOUBLE_LATENCY_EN (RWDS-driven 2x latency).
module hyperbus_ck_sequencer
    import hyperbus_pkg::*;
#(
    parameter int BURST_W = 16,
    parameter int LAT_W   = 4,
    parameter int CSS_CYC = 1,
    parameter int CSH_CYC = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trans_valid_i,
    output logic               trans_ready_o,
    input  logic [BURST_W-1:0] trans_burst_i,
    input  logic [LAT_W-1:0]   trans_latency_i,
    input  logic               rwds_i,
    input  logic               data_stall_i,
    output logic               ck_en_o,
    output logic               cs_no,
    output logic [2:0]         phase_o,
    output logic [1:0]         ca_idx_o,
    output logic [BURST_W-1:0] data_cnt_o,
    output logic               done_o
);

    localparam int CSX_MAX = (CSS_CYC > CSH_CYC) ? CSS_CYC : CSH_CYC;
    localparam int CSX_W   = $clog2(CSX_MAX + 1);
`ifdef HYPERBUS_DOUBLE_LATENCY_EN
    localparam int LATC_W  = LAT_W + 1;
`else
    localparam int LATC_W  = LAT_W;
`endif

    hyper_phase_e       state_q, state_d;
    logic               cs_n_q, ck_en_q, ck_en_d;
    logic [1:0]         ca_idx_q, ca_idx_d;
    logic [BURST_W-1:0] burst_q;
    logic [LAT_W-1:0]   lat_q;

    logic               csx_load, csx_en, csx_zero;
    logic [CSX_W-1:0]   csx_val, csx_cnt_unused;
    logic               lat_load, lat_en, lat_zero;
    logic [LATC_W-1:0]  lat_val, lat_cnt_unused;
    logic               dat_load, dat_en, dat_zero;
    logic [BURST_W-1:0] dat_cnt;

    // RWDS is looked at only on the CA->LAT edge, i.e. while ca_idx is 2.
`ifdef HYPERBUS_DOUBLE_LATENCY_EN
    assign lat_val = rwds_i ? ({lat_q, 1'b0} - LATC_W'(1))
                            : ({1'b0, lat_q} - LATC_W'(1));
`else
    logic rwds_unused;
    assign rwds_unused = rwds_i;
    assign lat_val     = lat_q - LAT_W'(1);
`endif

    hyperbus_phase_cnt #(.W(CSX_W)) u_csx_cnt (
        .clk(clk_i), .rst(rst_i), .load(csx_load), .load_val(csx_val),
        .en(csx_en), .count(csx_cnt_unused), .zero(csx_zero)
    );

    hyperbus_phase_cnt #(.W(LATC_W)) u_lat_cnt (
        .clk(clk_i), .rst(rst_i), .load(lat_load), .load_val(lat_val),
        .en(lat_en), .count(lat_cnt_unused), .zero(lat_zero)
    );

    hyperbus_phase_cnt #(.W(BURST_W)) u_dat_cnt (
        .clk(clk_i), .rst(rst_i), .load(dat_load), .load_val(burst_q - BURST_W'(1)),
        .en(dat_en), .count(dat_cnt), .zero(dat_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= PH_IDLE;
            cs_n_q   <= 1'b1;
            ck_en_q  <= 1'b0;
            ca_idx_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cs_n_q   <= (state_d == PH_IDLE);
            ck_en_q  <= ck_en_d;
            ca_idx_q <= ca_idx_d;
        end
    end

    // Descriptor fields are plain data and need no reset.
    always_ff @(posedge clk_i) begin
        if (trans_valid_i && state_q == PH_IDLE) begin
            burst_q <= (trans_burst_i == '0) ? BURST_W'(1) : trans_burst_i;
            lat_q   <= trans_latency_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        ca_idx_d = 2'd0;
        csx_load = 1'b0;
        csx_val  = '0;
        csx_en   = 1'b0;
        lat_load = 1'b0;
        lat_en   = 1'b0;
        dat_load = 1'b0;
        dat_en   = 1'b0;
        ck_en_d  = 1'b0;
        case (state_q)
            PH_IDLE: if (trans_valid_i) begin
                state_d  = PH_CSS;
                csx_load = 1'b1;
                csx_val  = CSX_W'(CSS_CYC - 1);
            end
            PH_CSS: if (csx_zero) state_d = PH_CA; else csx_en = 1'b1;
            PH_CA: begin
                if (ca_idx_q == 2'(CA_CYCLES - 1)) begin
                    if (lat_q != '0) begin
                        state_d  = PH_LAT;
                        lat_load = 1'b1;
                    end else begin
                        state_d  = PH_DATA;
                        dat_load = 1'b1;
                    end
                end else begin
                    ca_idx_d = ca_idx_q + 2'd1;
                end
            end
            PH_LAT: if (lat_zero) begin
                state_d  = PH_DATA;
                dat_load = 1'b1;
            end else begin
                lat_en = 1'b1;
            end
            // Only cycles that actually produced a CK edge count as data.
            PH_DATA: if (ck_en_q) begin
                if (dat_zero) begin
                    state_d  = PH_CSH;
                    csx_load = 1'b1;
                    csx_val  = CSX_W'(CSH_CYC - 1);
                end else begin
                    dat_en = 1'b1;
                end
            end
            PH_CSH: if (csx_zero) state_d = PH_IDLE; else csx_en = 1'b1;
            default: state_d = PH_IDLE;
        endcase
        case (state_d)
            PH_CA, PH_LAT: ck_en_d = 1'b1;
            PH_DATA:       ck_en_d = (state_q == PH_DATA) ? !data_stall_i : 1'b1;
            default:       ck_en_d = 1'b0;
        endcase
    end

    assign trans_ready_o = (state_q == PH_IDLE);
    assign ck_en_o       = ck_en_q;
    assign cs_no         = cs_n_q;
    assign phase_o       = state_q;
    assign ca_idx_o      = ca_idx_q;
    assign data_cnt_o    = (state_q == PH_DATA) ? (burst_q - BURST_W'(1) - dat_cnt) : '0;
    assign done_o        = (state_q == PH_CSH) && csx_zero;

endmodule

// File: tb/tb_hyperbus_ck_sequencer.sv
// Self-checking bench for hyperbus_ck_sequencer; expected per-cycle timelines
// are built from the phase rules (honours HYPERBUS_DOUBLE_LATENCY_EN).
module tb_hyperbus_ck_sequencer;

    localparam int BURST_W = 16;
    localparam int LAT_W   = 4;
    localparam int CSS_CYC = 1;
    localparam int CSH_CYC = 1;
`ifdef HYPERBUS_DOUBLE_LATENCY_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               trans_valid;
    logic               trans_ready;
    logic [BURST_W-1:0] trans_burst;
    logic [LAT_W-1:0]   trans_latency;
    logic               rwds;
    logic               data_stall;
    logic               ck_en;
    logic               cs_n;
    logic [2:0]         phase;
    logic [1:0]         ca_idx;
    logic [BURST_W-1:0] data_cnt;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    bit stall_pat [0:255];
    bit rwds_pat  [0:255];

    typedef struct {
        logic [2:0]  ph;
        logic        cs;
        logic        ck;
        logic        dn;
        logic [1:0]  idx;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    hyperbus_ck_sequencer #(
        .BURST_W(BURST_W), .LAT_W(LAT_W), .CSS_CYC(CSS_CYC), .CSH_CYC(CSH_CYC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .trans_valid_i(trans_valid), .trans_ready_o(trans_ready),
        .trans_burst_i(trans_burst), .trans_latency_i(trans_latency), .rwds_i(rwds),
        .data_stall_i(data_stall), .ck_en_o(ck_en), .cs_no(cs_n), .phase_o(phase),
        .ca_idx_o(ca_idx), .data_cnt_o(data_cnt), .done_o(done)
    );

    always #5 clk = ~clk;

    function automatic bit stall_at(int t);
        return (t >= 0 && t < 256) ? stall_pat[t] : 1'b0;
    endfunction

    function automatic bit rwds_at(int t);
        return (t >= 0 && t < 256) ? rwds_pat[t] : 1'b0;
    endfunction

    function automatic exp_t mk(int ph, bit cs, bit ck, bit dn, int idx, int cnt);
        exp_t e;
        e.ph = 3'(ph); e.cs = cs; e.ck = ck; e.dn = dn; e.idx = 2'(idx); e.cnt = 16'(cnt);
        return e;
    endfunction

    function automatic void clear_pats();
        for (int i = 0; i < 256; i++) begin
            stall_pat[i] = 1'b0;
            rwds_pat[i]  = 1'b0;
        end
    endfunction

    // Timeline entry k describes cycle t=k+1 after the accepting edge.
    task automatic build_expected(input int b_in, input int l_in);
        int b = (b_in == 0) ? 1 : b_in;
        int t = 1;
        int got = 0;
        bit dbl = 1'b0;
        bit ck;
        exp_q.delete();
        for (int i = 0; i < CSS_CYC; i++) begin exp_q.push_back(mk(1, 0, 0, 0, 0, 0)); t++; end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(2, 0, 1, 0, i, 0));
            if (i == 2) dbl = DBL_EN && rwds_at(t);
            t++;
        end
        for (int i = 0; i < l_in * (dbl ? 2 : 1); i++) begin exp_q.push_back(mk(3, 0, 1, 0, 0, 0)); t++; end
        ck = 1'b1;
        while (got < b) begin
            exp_q.push_back(mk(4, 0, ck, 0, 0, got));
            if (ck) got++;
            ck = !stall_at(t);
            t++;
        end
        for (int i = 0; i < CSH_CYC; i++) begin exp_q.push_back(mk(5, 0, 0, (i == CSH_CYC - 1), 0, 0)); t++; end
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    endtask

    // Entered and left #1 after a posedge with the DUT idle.
    task automatic run_trans(input string name, input int b, input int l,
                             output int ck_tot, output int ck_run, output int cs_low,
                             output int dn_cnt, output int data_ck, output int data_gap,
                             output int lat_cyc);
        int run = 0;
        exp_t e;
        build_expected(b, l);
        ck_tot = 0; ck_run = 0; cs_low = 0; dn_cnt = 0; data_ck = 0; data_gap = 0; lat_cyc = 0;
        trans_valid   = 1'b1;
        trans_burst   = 16'(b);
        trans_latency = 4'(l);
        data_stall    = stall_at(0);
        rwds          = rwds_at(0);
        @(posedge clk); #1;
        trans_valid = 1'b0;
        for (int t = 1; t <= exp_q.size(); t++) begin
            data_stall = stall_at(t);
            rwds       = rwds_at(t);
            @(negedge clk);
            e = exp_q[t-1];
            n_checks++;
            if (phase !== e.ph || cs_n !== e.cs || ck_en !== e.ck || done !== e.dn ||
                trans_ready !== (e.ph == 3'd0) ||
                (e.ph == 3'd2 && ca_idx !== e.idx) ||
                (e.ph == 3'd4 && data_cnt !== e.cnt)) begin
                n_fail++;
                $display("FAIL %s t=%0d got ph=%0d cs=%b ck=%b dn=%b rdy=%b idx=%0d cnt=%0d want ph=%0d cs=%b ck=%b dn=%b idx=%0d cnt=%0d",
                         name, t, phase, cs_n, ck_en, done, trans_ready, ca_idx, data_cnt,
                         e.ph, e.cs, e.ck, e.dn, e.idx, e.cnt);
            end
            if (ck_en === 1'b1) begin
                ck_tot++; run++;
                if (run > ck_run) ck_run = run;
            end else begin
                run = 0;
            end
            if (cs_n === 1'b0) cs_low++;
            if (done === 1'b1) dn_cnt++;
            if (phase === 3'd4 && ck_en === 1'b1) data_ck++;
            if (phase === 3'd4 && ck_en === 1'b0) data_gap++;
            if (phase === 3'd3) lat_cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (cs_n !== 1'b1 || ck_en !== 1'b0 || phase !== 3'd0 || ca_idx !== 2'd0 ||
            data_cnt !== 16'd0 || done !== 1'b0 || trans_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values got cs=%b ck=%b ph=%0d idx=%0d cnt=%0d dn=%b rdy=%b want cs=1 ck=0 ph=0 idx=0 cnt=0 dn=0 rdy=1",
                     cs_n, ck_en, phase, ca_idx, data_cnt, done, trans_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_read();
        int ck_tot, ck_run, cs_low, dn, dck, dgap, latc;
        clear_pats();
        run_trans("basic_read", 4, 6, ck_tot, ck_run, cs_low, dn, dck, dgap, latc);
        n_checks++;
        if (cs_low != 15) begin n_fail++; $display("FAIL basic_cs_low got %0d want 15", cs_low); end
        n_checks++;
        if (ck_run != 13 || ck_tot != 13) begin
            n_fail++; $display("FAIL basic_ck_run got run=%0d total=%0d want 13/13", ck_run, ck_tot);
        end
        n_checks++;
        if (dn != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", dn); end
    endtask

    task automatic test_double_latency();
        int ck_tot, ck_run, cs_low, dn, dck, dgap, latc;
        clear_pats();
        for (int i = 0; i < 256; i++) rwds_pat[i] = 1'b1;
        run_trans("double_latency", 4, 6, ck_tot, ck_run, cs_low, dn, dck, dgap, latc);
        n_checks++;
        if (latc != (DBL_EN ? 12 : 6)) begin
            n_fail++; $display("FAIL dbl_lat_cycles got %0d want %0d", latc, DBL_EN ? 12 : 6);
        end
        n_checks++;
        if (ck_tot != (DBL_EN ? 19 : 13)) begin
            n_fail++; $display("FAIL dbl_ck_total got %0d want %0d", ck_tot, DBL_EN ? 19 : 13);
        end
    endtask

    task automatic test_zero_latency();
        int ck_tot, ck_run, cs_low, dn, dck, dgap, latc;
        clear_pats();
        run_trans("zero_latency", 0, 0, ck_tot, ck_run, cs_low, dn, dck, dgap, latc);
        n_checks++;
        if (ck_tot != 4 || latc != 0 || dck != 1) begin
            n_fail++; $display("FAIL zero_lat_counts got ck=%0d lat=%0d data=%0d want 4/0/1", ck_tot, latc, dck);
        end
    endtask

    task automatic test_stall();
        int ck_tot, ck_run, cs_low, dn, dck, dgap, latc;
        clear_pats();
        // DATA starts at t=7; stalls before that must be ignored.
        for (int t = 2; t <= 6; t++) stall_pat[t] = 1'b1;
        for (int t = 9; t <= 13; t++) stall_pat[t] = 1'b1;
        run_trans("stall", 8, 2, ck_tot, ck_run, cs_low, dn, dck, dgap, latc);
        n_checks++;
        if (dgap != 5) begin n_fail++; $display("FAIL stall_gap got %0d want 5", dgap); end
        n_checks++;
        if (dck != 8) begin n_fail++; $display("FAIL stall_data_ck got %0d want 8", dck); end
    endtask

    task automatic test_random();
        int ck_tot, ck_run, cs_low, dn, dck, dgap, latc;
        int b, l, want;
        bit dbl;
        for (int k = 0; k < 25; k++) begin
            clear_pats();
            for (int i = 0; i < 256; i++) begin
                stall_pat[i] = ($urandom_range(0, 3) == 0);
                rwds_pat[i]  = $urandom_range(0, 1);
            end
            b = $urandom_range(0, 12);
            l = $urandom_range(0, 15);
            dbl = DBL_EN && rwds_pat[CSS_CYC + 3];
            run_trans("random", b, l, ck_tot, ck_run, cs_low, dn, dck, dgap, latc);
            want = 3 + l * (dbl ? 2 : 1) + ((b == 0) ? 1 : b);
            n_checks++;
            if (ck_tot != want || dn != 1) begin
                n_fail++;
                $display("FAIL random_ck_total iter=%0d b=%0d l=%0d got ck=%0d done=%0d want ck=%0d done=1",
                         k, b, l, ck_tot, dn, want);
            end
        end
    endtask

    task automatic test_reset_mid_lat();
        bit found = 1'b0;
        int dn = 0;
        int busy = 0;
        clear_pats();
        data_stall = 1'b0; rwds = 1'b0;
        trans_valid = 1'b1; trans_burst = 16'd4; trans_latency = 4'd6;
        @(posedge clk); #1;
        trans_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (phase === 3'd3) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rst_lat_reach got no LAT phase want LAT within 20 cycles"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cs_n !== 1'b1 || ck_en !== 1'b0 || phase !== 3'd0 || trans_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_lat_state got cs=%b ck=%b ph=%0d rdy=%b dn=%b want cs=1 ck=0 ph=0 rdy=1 dn=0",
                     cs_n, ck_en, phase, trans_ready, done);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (phase !== 3'd0) busy++;
        end
        n_checks++;
        if (dn != 0 || busy != 0) begin
            n_fail++; $display("FAIL rst_lat_quiet got done=%0d busy=%0d want 0/0", dn, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit seen;
        int early_rdy = 0;
        data_stall = 1'b0; rwds = 1'b0;
        trans_valid = 1'b1; trans_burst = 16'd2; trans_latency = 4'd1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
            if (trans_ready === 1'b1) early_rdy++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!seen || early_rdy != 0 || trans_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first got done_seen=%b early_ready=%0d rdy_at_done=%b want 1/0/0", seen, early_rdy, trans_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (phase !== 3'd0 || cs_n !== 1'b1 || trans_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap got ph=%0d cs=%b rdy=%b want ph=0 cs=1 rdy=1", phase, cs_n, trans_ready);
        end
        @(posedge clk); #1;
        trans_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (phase !== 3'd1 || cs_n !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_start got ph=%0d cs=%b want ph=1 cs=0", phase, cs_n);
        end
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (!seen || phase !== 3'd0 || trans_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_end got done_seen=%b ph=%0d rdy=%b want 1/0/1", seen, phase, trans_ready);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; trans_valid = 1'b0; trans_burst = '0; trans_latency = '0;
        rwds = 1'b0; data_stall = 1'b0;
        clear_pats();
        test_reset();
        test_basic_read();
        test_double_latency();
        test_zero_latency();
        test_stall();
        test_random();
        test_reset_mid_lat();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_ck_sequencer.md
# hyperbus_ck_sequencer

Transaction-phase sequencer generating the HyperBus CK enable and chip-select for one transaction. Accepts a transaction descriptor, walks the chip-select setup, command-address, latency, data and chip-select hold phases, and drives `ck_en_o` into the gated differential CK output stage directly downstream. It also exports phase and index signals used by the CA shifter and the data TX/RX paths.

## Interface
- `BURST_W`, 16: width of the data-burst length in CK cycles.
- `LAT_W`, 4: width of the initial-latency count in CK cycles.
- `CSS_CYC`, 1: CS# low to first CK enable, in cycles (≥1).
- `CSH_CYC`, 1: last CK enable to CS# high, in cycles (≥1).

Ports:
- `clk_i` in 1: single clock (CK rate). Reset is synchronous and active-high.
- `rst_i` in 1: synchronous, active-high reset.
- `trans_valid_i` in 1: descriptor valid.
- `trans_ready_o` out 1: descriptor accepted when valid&ready.
- `trans_burst_i` in BURST_W: data CK cycles; value 0 treated as 1.
- `trans_latency_i` in LAT_W: initial latency cycles; 0 = zero-latency (register write).
- `rwds_i` in 1: RWDS already synchronised; sampled on the last CA cycle.
- `data_stall_i` in 1: downstream data path not ready; pauses CK in DATA.
- `ck_en_o` out 1: CK enable to the differential clock stage; registered.
- `cs_no` out 1: chip select, active low; registered.
- `phase_o` out 3: 0 IDLE, 1 CSS, 2 CA, 3 LAT, 4 DATA, 5 CSH.
- `ca_idx_o` out 2: CA cycle index 0..2, valid in CA.
- `data_cnt_o` out BURST_W: data cycles completed, valid in DATA.
- `done_o` out 1: one-cycle pulse on the last CSH cycle.

## Operation
- `trans_ready_o` = (state==IDLE). The handshake latches the burst and latency values, and the state moves to CSS.
- **CSS:**
  - `cs_no`=0, `ck_en_o`=0.
  - Lasts `CSS_CYC` cycles, then moves to CA.
- **CA:**
  - `ck_en_o`=1 for exactly 3 cycles; `ca_idx_o` counts 0,1,2.
  - `rwds_i` is captured on `ca_idx_o`==2 to form `dbl_lat`.
  - Next state: LAT if latency≠0, else DATA.
- **LAT:**
  - `ck_en_o`=1.
  - Duration is latency cycles, or 2×latency when `dbl_lat`=1.
  - The LAT counter width is LAT_W+1, so the product cannot overflow.
- **DATA:**
  - `ck_en_o` = !`data_stall_i`, registered.
  - `data_cnt_o` increments only on cycles with `ck_en_o`=1.
  - When the count reaches the burst value, the state moves to CSH.
- **CSH:**
  - `ck_en_o`=0, `cs_no`=0 for `CSH_CYC` cycles.
  - `done_o` pulses on the final cycle, then the state returns to IDLE with `cs_no`=1.
- **Stall behaviour:**
  - A stall asserted in any phase other than DATA is ignored.
  - A stall held indefinitely keeps the state in DATA with CK stopped.
- **Reset:**
  - `rst_i` in any state returns to IDLE on the next edge.
  - Reset values: `cs_no`=1, `ck_en_o`=0, `phase_o`=0, `ca_idx_o`=0, `data_cnt_o`=0, `done_o`=0, `trans_ready_o`=1.
- A new descriptor presented while `done_o` is high is not accepted until the following IDLE cycle.

## Timing
- Handshake at edge N gives: `cs_no` falls at N+1; first `ck_en_o`=1 at N+1+CSS_CYC.
- CK-enabled cycles with no stall = 3 + L·(1+dbl_lat) + max(burst,1).
- `ck_en_o` falls at least one cycle before `cs_no` rises (CSH_CYC≥1).
- Minimum IDLE-to-IDLE transaction time = 1 + CSS_CYC + 3 + L' + B + CSH_CYC.
- `ck_en_o` is glitch-free (flop output). The downstream clock gate latches it on the low phase.
- `data_stall_i` to `ck_en_o` latency is 1 cycle. The data path must account for one CK edge after stall assertion.

## Configuration
- **`HYPERBUS_DOUBLE_LATENCY_EN` defined:** `rwds_i` is sampled as described and can double the latency.
- **Not defined:** `rwds_i` is ignored and `dbl_lat` is tied 0, so latency is always single.
  - The port remains present.
  - The LAT counter width is LAT_W.

## Structure
- Shared package `hyperbus_pkg`:
  - `hyper_phase_e` enum (3-bit encoding above).
  - `CA_CYCLES`=3 constant.
- Sub-module `hyperbus_phase_cnt`: a loadable down-counter with enable and a zero flag. It is instantiated for the CSS/CSH, LAT and DATA counts.

## Test plan
- **Basic read:** burst=4, latency=6, rwds=0, no stall, CSS=CSH=1.
  - `cs_no` low for 15 cycles.
  - `ck_en_o` high for 13 consecutive cycles.
  - `done_o` pulses once.
- **Double latency:** same descriptor with rwds=1 at ca_idx 2.
  - LAT lasts 12 cycles; 19 CK-enabled cycles total.
  - With the macro undefined: 13 cycles.
- **Zero-latency burst-0 register write:**
  - Phase sequence CSS→CA→DATA→CSH.
  - 4 CK-enabled cycles.
- **Stall:** `data_stall_i` high for 5 cycles mid-DATA, burst=8.
  - `ck_en_o` low exactly 5 cycles (shifted by 1).
  - `data_cnt_o` frozen during the stall; 8 data CK cycles total.
- **Reset mid-LAT:** assert `rst_i` during LAT.
  - Next cycle: `cs_no`=1, `ck_en_o`=0, `phase_o`=0, `trans_ready_o`=1.
  - No `done_o` pulse.
- **Back-to-back:** `trans_valid_i` held high for two descriptors.
  - The second is accepted only in the IDLE cycle after `done_o`.
  - `cs_no` high for ≥1 cycle between the transactions.
